bf_control: RTL and testbench

BF_CONTROL -- requirements
Module: bf_control

---
 rtl/bf_control.sv | 181 ++++++++++++++++++
 tb/tb_bf_control.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bf_control.sv
// Sequencer for a byte-coded bracket language: fetches from program memory, drives a data
// memory port, runs byte-in/byte-out handshakes and skips over loops with a nesting counter.
module bf_control #(
    parameter int DEPTH_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] pc,
    input  logic [7:0] instr,
    output logic [7:0] dp,
    input  logic [7:0] drdata,
    output logic [7:0] dwdata,
    output logic       dwe,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_OPEN  = 8'h5B;
    localparam logic [7:0] OP_CLOSE = 8'h5D;
    localparam logic [7:0] OP_END   = 8'h00;

    localparam logic [DEPTH_W-1:0] D_ONE = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] D_MAX = {DEPTH_W{1'b1}};

    typedef enum logic [2:0] {IDLE, RUN, SCAN_FWD, SCAN_BWD, HALT} state_t;

    state_t             state;
    logic [DEPTH_W-1:0] depth;

    // Memory-side strobes follow the byte being decoded this cycle; only RUN may touch memory or I/O.
    always_comb begin
        dwe       = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dwdata    = drdata;
        out_data  = drdata;
        if (state == RUN) begin
            case (instr)
                OP_INC: begin
                    dwe    = 1'b1;
                    dwdata = drdata + 8'd1;
                end
                OP_DEC: begin
                    dwe    = 1'b1;
                    dwdata = drdata - 8'd1;
                end
                OP_IN: begin
                    in_ready = 1'b1;
                    dwe      = in_valid;
                    dwdata   = in_data;
                end
                OP_OUT:  out_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == SCAN_FWD) || (state == SCAN_BWD);
    assign done = (state == HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= 8'd0;
            dp    <= 8'd0;
            depth <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state <= RUN;
                        pc    <= 8'd0;
                        dp    <= 8'd0;
                        depth <= '0;
                        err   <= 1'b0;
                    end
                end
                RUN: begin
                    case (instr)
                        OP_END: state <= HALT;
                        OP_RIGHT: begin
                            dp <= dp + 8'd1;
                            pc <= pc + 8'd1;
                        end
                        OP_LEFT: begin
                            dp <= dp - 8'd1;
                            pc <= pc + 8'd1;
                        end
                        OP_IN:  if (in_valid)  pc <= pc + 8'd1;
                        OP_OUT: if (out_ready) pc <= pc + 8'd1;
                        OP_OPEN: begin
                            pc <= pc + 8'd1;
                            if (drdata == 8'd0) begin
                                depth <= D_ONE;
                                state <= SCAN_FWD;
                            end
                        end
                        OP_CLOSE: begin
                            if (drdata == 8'd0) begin
                                pc <= pc + 8'd1;
                            end else begin
                                depth <= D_ONE;
                                pc    <= pc - 8'd1;
                                state <= SCAN_BWD;
                            end
                        end
                        default: pc <= pc + 8'd1;
                    endcase
                end
                SCAN_FWD: begin
                    case (instr)
                        OP_END: begin
                            err   <= 1'b1;
                            state <= HALT;
                        end
                        OP_OPEN: begin
                            if (depth == D_MAX) begin
                                err   <= 1'b1;
                                state <= HALT;
                            end else begin
                                depth <= depth + D_ONE;
                                pc    <= pc + 8'd1;
                            end
                        end
                        OP_CLOSE: begin
                            pc <= pc + 8'd1;
                            if (depth == D_ONE) state <= RUN;
                            else                depth <= depth - D_ONE;
                        end
                        default: pc <= pc + 8'd1;
                    endcase
                end
                SCAN_BWD: begin
                    // Walking backwards; the matching '[' resumes execution just after itself.
                    case (instr)
                        OP_END: begin
                            err   <= 1'b1;
                            state <= HALT;
                        end
                        OP_CLOSE: begin
                            if (depth == D_MAX) begin
                                err   <= 1'b1;
                                state <= HALT;
                            end else begin
                                depth <= depth + D_ONE;
                                pc    <= pc - 8'd1;
                            end
                        end
                        OP_OPEN: begin
                            if (depth == D_ONE) begin
                                pc    <= pc + 8'd1;
                                state <= RUN;
                            end else begin
                                depth <= depth - D_ONE;
                                pc    <= pc - 8'd1;
                            end
                        end
                        default: pc <= pc - 8'd1;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_control.sv
// Directed bench for bf_control: table of whole programs plus hand-timed handshake and reset sequences.
module tb_bf_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pc, instr, dp, drdata, dwdata, in_data, out_data;
    logic       dwe, in_valid, in_ready, out_valid, out_ready, busy, done, err;

    logic [7:0] pmem [256];
    logic [7:0] dmem [256];
    logic       clr;
    int         wr_cnt, out_cnt;
    logic [7:0] last_out;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        string      prog;
        logic [7:0] out_val;
        int         out_n;
        logic [7:0] dp_val;
        logic       err_val;
        logic [7:0] addr;
        logic [7:0] mem_val;
        int         wr_n;
    } vec_t;

    vec_t vecs[8];

    bf_control #(.DEPTH_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr), .dp(dp),
        .drdata(drdata), .dwdata(dwdata), .dwe(dwe), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign instr  = pmem[pc];
    assign drdata = dmem[dp];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
            wr_cnt   <= 0;
            out_cnt  <= 0;
            last_out <= 8'h00;
        end else begin
            if (dwe) begin
                dmem[dp] <= dwdata;
                wr_cnt   <= wr_cnt + 1;
            end
            if (out_valid && out_ready) begin
                last_out <= out_data;
                out_cnt  <= out_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 256; i++) pmem[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    task automatic clear_mem();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 2000) begin
            check({name, ".excl"}, 32'(dwe) + 32'(in_ready) + 32'(out_valid) <= 1, 1);
            tick();
            k++;
        end
        check({name, ".finished"}, done, 1'b1);
    endtask

    initial begin
        vecs[0] = '{"+++.",       8'h03, 1, 8'h00, 1'b0, 8'h00, 8'h03, 3};
        vecs[1] = '{"<-.",        8'hFF, 1, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1};
        vecs[2] = '{"[+[-]].",    8'h00, 1, 8'h00, 1'b0, 8'h00, 8'h00, 0};
        vecs[3] = '{"++[>+<-]>.", 8'h02, 1, 8'h01, 1'b0, 8'h01, 8'h02, 6};
        vecs[4] = '{"[[",         8'h00, 0, 8'h00, 1'b1, 8'h00, 8'h00, 0};
        vecs[5] = '{"+]",         8'h00, 0, 8'h00, 1'b1, 8'h00, 8'h01, 1};
        vecs[6] = '{"a+b+.",      8'h02, 1, 8'h00, 1'b0, 8'h00, 8'h02, 2};
        vecs[7] = '{"-+.",        8'h00, 1, 8'h00, 1'b0, 8'h00, 8'h00, 2};

        reset = 1'b1; start = 1'b0; clr = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        load("");
        #2;
        check("rst.pc", pc, 8'h00);
        check("rst.dp", dp, 8'h00);
        check("rst.busy_done_err", {busy, done, err}, 3'b000);
        check("rst.strobes", {dwe, in_ready, out_valid}, 3'b000);
        tick();
        reset = 1'b0;
        tick(); tick();
        check("idle.hold", {busy, done, pc}, {2'b00, 8'h00});

        // Whole programs from the table
        in_valid = 1'b1;
        for (int v = 0; v < 8; v++) begin
            load(vecs[v].prog);
            clear_mem();
            pulse_start();
            wait_done(vecs[v].prog);
            check({vecs[v].prog, ".busy"}, busy, 1'b0);
            check({vecs[v].prog, ".err"}, err, vecs[v].err_val);
            check({vecs[v].prog, ".dp"}, dp, vecs[v].dp_val);
            check({vecs[v].prog, ".outs"}, out_cnt, vecs[v].out_n);
            check({vecs[v].prog, ".out"}, last_out, vecs[v].out_val);
            check({vecs[v].prog, ".writes"}, wr_cnt, vecs[v].wr_n);
            check({vecs[v].prog, ".mem"}, dmem[vecs[v].addr], vecs[v].mem_val);
        end
        in_valid = 1'b0;

        // "+++." cycle by cycle
        load("+++.");
        clear_mem();
        pulse_start();
        check("t1.c1.write", {dwe, dwdata}, {1'b1, 8'h01});
        tick();
        check("t1.c2.write", {dwe, dwdata}, {1'b1, 8'h02});
        tick();
        check("t1.c3.write", {dwe, dwdata}, {1'b1, 8'h03});
        tick();
        check("t1.c4.out", {out_valid, out_data, dwe}, {1'b1, 8'h03, 1'b0});
        tick();
        check("t1.c5.busy", {busy, done}, 2'b10);
        tick();
        check("t1.c6.done", {busy, done}, 2'b01);

        // ",." with stalled input then stalled output
        load(",.");
        clear_mem();
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            check("t2.in_stall", {in_ready, dwe, pc}, {2'b10, 8'h00});
            tick();
        end
        in_valid = 1'b1; in_data = 8'h41;
        #1;
        check("t2.in_take", {dwe, dwdata}, {1'b1, 8'h41});
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2.out_stall", {out_valid, out_data, in_ready, dwe, pc}, {1'b1, 8'h41, 2'b00, 8'h01});
            if (i == 1) start = 1'b1;
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        #1;
        check("t2.out_go", {out_valid, pc}, {1'b1, 8'h01});
        tick();
        check("t2.pc_adv", {out_valid, pc}, {1'b0, 8'h02});
        tick();
        check("t2.done", {done, err, last_out}, {2'b10, 8'h41});
        check("t2.counts", {out_cnt[7:0], wr_cnt[7:0], dmem[0]}, {8'd1, 8'd1, 8'h41});

        // Unmatched bracket, then reset in the middle of a forward scan
        load(">[[");
        clear_mem();
        pulse_start();
        wait_done("t3");
        check("t3.err", {err, done, dp}, {2'b11, 8'h01});
        pulse_start();
        check("t3.restart", {err, busy, pc}, {2'b01, 8'h00});
        tick(); tick();
        check("t3.scanning", {busy, dp, pc}, {1'b1, 8'h01, 8'h02});
        #2;
        reset = 1'b1;
        #1;
        check("t3.rst.regs", {pc, dp, err}, {8'h00, 8'h00, 1'b0});
        check("t3.rst.outs", {dwe, in_ready, out_valid, busy, done}, 5'b00000);
        #3;
        reset = 1'b0;
        tick(); tick(); tick();
        check("t3.idle", {busy, done, pc}, {2'b00, 8'h00});

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
